// File: rtl/apb_pkg.sv
// Shared APB definitions.
// The state encoding is common to the requester and the slave-side FSM so
// that both sides decode psel/penable phases identically.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB requester.
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   clear_i   zero the count (asserted in the cycle before ACCESS)
//   en_i      count one more wait state (ACCESS with pready low)
//   expired_o current ACCESS cycle is the TIMEOUT-th one
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  // The count holds the number of completed wait states, so the TIMEOUT-th
  // ACCESS cycle is the one where it reads TIMEOUT-1.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: converts one valid/ready command into a single APB transfer
// (SETUP, then ACCESS with wait states) and returns a one-cycle response.
// Ports:
//   pclk, preset               clock / asynchronous active-low reset
//   cmd_valid/ready            command handshake (accepted only in IDLE)
//   cmd_write/addr/wdata       command contents
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata/rsp_err          response data / error, held until next response
//   psel/penable/pwrite/paddr/pwdata   APB request side
//   prdata/pready/pslverr      APB completion side
// A slave holding pready low for TIMEOUT ACCESS cycles is abandoned with
// rsp_err=1 and zero read data.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (pclk),
    .rst_ni    (preset),
    .clear_i   (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !pready),
    .expired_o (expired)
  );

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if ((state_q == IDLE) && cmd_valid) begin
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
      pwrite_d = cmd_write;
    end
    if (state_q == ACCESS) begin
      // pready takes priority so a completion on the last allowed cycle is
      // reported normally rather than as a timeout.
      if (pready) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = pslverr;
        rsp_rdata_d = pwrite_q ? '0 : prdata;
      end else if (expired) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign psel      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable   = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 pclk = ~pclk;

  apb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        err_in;
    int unsigned waits;      // ACCESS cycles with pready low before pready high
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_acc;    // expected ACCESS (penable) cycles
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transfer against a slave that stalls v.waits cycles.
  task automatic run_txn(input vec_t v, input string tag);
    int unsigned acc;
    logic        done;
    logic        unstable;
    logic [31:0] held;
    check({tag, " cmd_ready idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = ~v.wr;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    check({tag, " setup psel/penable"}, {30'd0, psel, penable}, 32'b10);
    check({tag, " setup paddr"}, paddr, v.addr);
    acc = 0;
    done = 1'b0;
    unstable = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge pclk); #1;
      if (rsp_valid) begin
        done = 1'b1;
        pready = 1'b0;
      end else if (penable) begin
        acc++;
        if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr || psel !== 1'b1)
          unstable = 1'b1;
        if (acc > v.waits) begin
          pready = 1'b1;
          prdata = v.prdata;
          pslverr = v.err_in;
        end else begin
          // Garbage while stalled: must not reach the response.
          pready = 1'b0;
          prdata = 32'hFFFF_FFFF;
          pslverr = 1'b1;
        end
      end
    end
    check({tag, " rsp seen"}, 32'(done), 32'd1);
    check({tag, " access cycles"}, acc, v.exp_acc);
    check({tag, " bus stable"}, 32'(unstable), 32'd0);
    check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({tag, " idle psel/penable/ready"}, {29'd0, psel, penable, cmd_ready}, 32'b001);
    held = rsp_rdata;
    @(posedge pclk); #1;
    check({tag, " rsp pulse width"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_rdata hold"}, rsp_rdata, held);
  endtask

  logic [31:0] b2b_addr[3];
  logic [31:0] b2b_data[3];
  int unsigned acc_cyc[3];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 0,  32'h0,         1'b0, 1};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 3,  32'h1234_5678, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 1'b1, 0,  32'hCAFE_F00D, 1'b1, 1};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         32'hAAAA_5555, 1'b0, 99, 32'h0,         1'b1, 4};
    vecs[4] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h7777_7777, 1'b0, 99, 32'h0,         1'b1, 4};
    vecs[5] = '{1'b0, 32'h0000_0048, 32'h0,         32'h0F0F_0F0F, 1'b0, 1,  32'h0F0F_0F0F, 1'b0, 2};
    vecs[6] = '{1'b1, 32'h0000_0050, 32'h1122_3344, 32'h9999_9999, 1'b1, 2,  32'h0,         1'b1, 3};

    preset = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #12;
    check("reset ready/psel/penable/rsp_valid", {28'd0, cmd_ready, psel, penable, rsp_valid}, 32'b1000);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err/pwrite", {30'd0, rsp_err, pwrite}, 32'b00);
    check("reset paddr", paddr, 32'h0);
    check("reset pwdata", pwdata, 32'h0);
    preset = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: cmd_valid held high across three commands.
    b2b_addr = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    b2b_data = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    begin
      int unsigned nacc, nrsp, badchg;
      logic [31:0] prev_addr;
      logic accepted;
      nacc = 0; nrsp = 0; badchg = 0;
      prev_addr = paddr;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = b2b_addr[0]; cmd_wdata = '0;
      pready = 1'b1; pslverr = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (paddr !== prev_addr && !(psel && !penable)) badchg++;
        prev_addr = paddr;
        if (rsp_valid) begin
          if (nrsp < 3) check($sformatf("b2b rsp%0d rdata", nrsp), rsp_rdata, b2b_data[nrsp]);
          nrsp++;
        end
        prdata = b2b_data[nrsp < 3 ? nrsp : 2];
        accepted = cmd_valid && cmd_ready;
        if (accepted && nacc < 3) begin
          acc_cyc[nacc] = cyc;
          nacc++;
        end
        @(posedge pclk); #1;
        if (accepted) begin
          if (nacc < 3) cmd_addr = b2b_addr[nacc];
          else cmd_valid = 1'b0;
        end
      end
      pready = 1'b0;
      check("b2b accepts", nacc, 32'd3);
      check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], 32'd3);
      check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], 32'd3);
      check("b2b rsp count", nrsp, 32'd3);
      check("b2b paddr changes outside setup", badchg, 32'd0);
    end

    // Reset asserted during a wait state.
    begin
      logic spurious;
      spurious = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0060;
      pready = 1'b0;
      @(posedge pclk); #1;  // SETUP
      cmd_valid = 1'b0;
      @(posedge pclk); #1;  // ACCESS 1
      @(posedge pclk); #1;  // ACCESS 2
      check("pre-reset penable", 32'(penable), 32'd1);
      #3 preset = 1'b0;
      #1;
      check("async reset psel/penable/ready", {29'd0, psel, penable, cmd_ready}, 32'b001);
      @(posedge pclk); #4;
      preset = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(posedge pclk); #1;
        if (rsp_valid) spurious = 1'b1;
      end
      check("no rsp after reset", 32'(spurious), 32'd0);
      run_txn(vecs[1], "post-reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
